// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: brings up a clocking wizard and sequences staged downstream resets
//   clk           system clock
//   sys_rst       synchronous active-high reset
//   locked        wizard lock flag (asynchronous, synchronized internally)
//   mmcm_rst      reset to the wizard
//   rst_out       staged active-high resets, bit 0 released first
//   ready         all stages released and lock held
//   fault         sticky, wizard retries exhausted
//   retry_cnt     wizard retries used in the current lock attempt
//   lock_loss_cnt saturating count of lock losses in RELEASE/RUN
module clk_rst_sequencer #(
   parameter int LOCK_STABLE  = 16,
   parameter int LOCK_TIMEOUT = 1000,
   parameter int RST_PULSE    = 8,
   parameter int N_RST        = 3,
   parameter int STAGE_GAP    = 4,
   parameter int MAX_RETRY    = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             locked,
   output logic             mmcm_rst,
   output logic [N_RST-1:0] rst_out,
   output logic             ready,
   output logic             fault,
   output logic [1:0]       retry_cnt,
   output logic [CNT_W-1:0] lock_loss_cnt
);
   localparam int REL_LEN = STAGE_GAP * N_RST;
   localparam int TMAX = (LOCK_TIMEOUT > RST_PULSE)
      ? ((LOCK_TIMEOUT > REL_LEN) ? LOCK_TIMEOUT : REL_LEN)
      : ((RST_PULSE > REL_LEN) ? RST_PULSE : REL_LEN);
   localparam int TW = $clog2(TMAX + 1);
   localparam int SW = $clog2(LOCK_STABLE + 1);
   typedef enum logic [2:0] {MMCM_RST, WAIT_LOCK, RELEASE, RUN, FAULT} state_t;
   state_t             state, state_n;
   logic [1:0]         sync;
   logic               locked_s;
   logic [TW-1:0]      tmr, tmr_n;
   logic [SW-1:0]      stab, stab_n;
   logic               mm_n, rd_n, ft_n;
   logic [N_RST-1:0]   ro_n;
   logic [1:0]         rc_n;
   logic [CNT_W-1:0]   lc_n;
   assign locked_s = sync[1];
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state         <= MMCM_RST;
         sync          <= '0;
         tmr           <= '0;
         stab          <= '0;
         mmcm_rst      <= 1'b1;
         rst_out       <= '1;
         ready         <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
      end else begin
         state         <= state_n;
         sync          <= {sync[0], locked};
         tmr           <= tmr_n;
         stab          <= stab_n;
         mmcm_rst      <= mm_n;
         rst_out       <= ro_n;
         ready         <= rd_n;
         fault         <= ft_n;
         retry_cnt     <= rc_n;
         lock_loss_cnt <= lc_n;
      end
   end
   // tmr is shared: pulse length in MMCM_RST, timeout in WAIT_LOCK, stage gap in RELEASE
   always_comb begin
      state_n = state;
      tmr_n   = tmr + TW'(1);
      stab_n  = '0;
      mm_n    = 1'b0;
      ro_n    = rst_out;
      rd_n    = 1'b0;
      ft_n    = 1'b0;
      rc_n    = retry_cnt;
      lc_n    = lock_loss_cnt;
      case (state)
         MMCM_RST: begin
            mm_n = 1'b1;
            ro_n = '1;
            if (tmr == TW'(RST_PULSE - 1)) begin
               state_n = WAIT_LOCK;
               tmr_n   = '0;
               mm_n    = 1'b0;
            end
         end
         WAIT_LOCK: begin
            ro_n   = '1;
            stab_n = locked_s ? stab + SW'(1) : '0;
            // stage 0 is released on the same edge RELEASE is entered
            if (locked_s && stab == SW'(LOCK_STABLE - 1)) begin
               state_n = RELEASE;
               tmr_n   = '0;
               stab_n  = '0;
               ro_n[0] = 1'b0;
            end else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
               tmr_n = '0;
               if (retry_cnt < 2'(MAX_RETRY)) begin
                  state_n = MMCM_RST;
                  rc_n    = retry_cnt + 2'd1;
                  mm_n    = 1'b1;
               end else begin
                  state_n = FAULT;
                  ft_n    = 1'b1;
               end
            end
         end
         RELEASE, RUN: begin
            if (!locked_s) begin
               state_n = WAIT_LOCK;
               tmr_n   = '0;
               ro_n    = '1;
               lc_n    = (&lock_loss_cnt) ? lock_loss_cnt : lock_loss_cnt + CNT_W'(1);
            end else if (state == RUN) begin
               tmr_n = '0;
               ro_n  = '0;
               rd_n  = 1'b1;
            end else begin
               for (int i = 1; i < N_RST; i++)
                  if (int'(tmr) + 1 == STAGE_GAP * i) ro_n[i] = 1'b0;
               if (int'(tmr) == STAGE_GAP * (N_RST - 1)) begin
                  state_n = RUN;
                  tmr_n   = '0;
                  rd_n    = 1'b1;
                  rc_n    = '0;
               end
            end
         end
         default: begin
            tmr_n = '0;
            ro_n  = '1;
            ft_n  = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: table-driven check of bring-up, retry, lock loss and reset cases
module tb_clk_rst_sequencer;
   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        locked = 1'b0;
   logic        mmcm_rst;
   logic [2:0]  rst_out;
   logic        ready;
   logic        fault;
   logic [1:0]  retry_cnt;
   logic [15:0] lock_loss_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   clk_rst_sequencer dut (
      .clk(clk), .sys_rst(sys_rst), .locked(locked), .mmcm_rst(mmcm_rst),
      .rst_out(rst_out), .ready(ready), .fault(fault), .retry_cnt(retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {
      int sc; int ncyc; int rise; int drop; int dlen; int rst_at;
   } scen_t;
   typedef struct {
      int sc; int n; logic mm; logic [2:0] ro; logic rd; logic ft; logic [1:0] rc; int lc;
   } vec_t;
   logic        cap_mm [0:4199];
   logic [2:0]  cap_ro [0:4199];
   logic        cap_rd [0:4199];
   logic        cap_ft [0:4199];
   logic [1:0]  cap_rc [0:4199];
   logic [15:0] cap_lc [0:4199];
   scen_t scens[$];
   vec_t  vecs[$];
   task automatic chk(input string nm, input int n, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s at n=%0d: got %0d, expected %0d", nm, n, act, exp_v);
      end
   endtask
   // values captured at a negedge are those present at the following posedge n
   task automatic run(input scen_t s);
      sys_rst = 1'b1;
      locked  = 1'b0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < s.ncyc; c++) begin
         sys_rst = (c == s.rst_at);
         locked  = (s.rise >= 0 && c >= s.rise) && !(c >= s.drop && c < s.drop + s.dlen);
         cap_mm[c] = mmcm_rst;
         cap_ro[c] = rst_out;
         cap_rd[c] = ready;
         cap_ft[c] = fault;
         cap_rc[c] = retry_cnt;
         cap_lc[c] = lock_loss_cnt;
         @(negedge clk);
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int k;
      scens.push_back('{1,  130,   20, -1, 0, -1});
      scens.push_back('{2,  100,   20, 30, 1, -1});
      scens.push_back('{3, 4100,   -1, -1, 0, -1});
      scens.push_back('{4,  120,   20, 60, 5, -1});
      scens.push_back('{5,  100,   20, 43, 3, -1});
      scens.push_back('{6,  100,   20, -1, 0, 40});
      scens.push_back('{7, 1160, 1100, -1, 0, -1});
      vecs.push_back('{1,    0, 1, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{1,    7, 1, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{1,    8, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{1,   37, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{1,   38, 0, 3'b110, 0, 0, 0, 0});
      vecs.push_back('{1,   41, 0, 3'b110, 0, 0, 0, 0});
      vecs.push_back('{1,   42, 0, 3'b100, 0, 0, 0, 0});
      vecs.push_back('{1,   45, 0, 3'b100, 0, 0, 0, 0});
      vecs.push_back('{1,   46, 0, 3'b000, 0, 0, 0, 0});
      vecs.push_back('{1,   47, 0, 3'b000, 1, 0, 0, 0});
      vecs.push_back('{1,  120, 0, 3'b000, 1, 0, 0, 0});
      vecs.push_back('{2,   48, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{2,   49, 0, 3'b110, 0, 0, 0, 0});
      vecs.push_back('{2,   57, 0, 3'b000, 0, 0, 0, 0});
      vecs.push_back('{2,   58, 0, 3'b000, 1, 0, 0, 0});
      vecs.push_back('{3, 1007, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{3, 1008, 1, 3'b111, 0, 0, 1, 0});
      vecs.push_back('{3, 1015, 1, 3'b111, 0, 0, 1, 0});
      vecs.push_back('{3, 1016, 0, 3'b111, 0, 0, 1, 0});
      vecs.push_back('{3, 2016, 1, 3'b111, 0, 0, 2, 0});
      vecs.push_back('{3, 3024, 1, 3'b111, 0, 0, 3, 0});
      vecs.push_back('{3, 3032, 0, 3'b111, 0, 0, 3, 0});
      vecs.push_back('{3, 4031, 0, 3'b111, 0, 0, 3, 0});
      vecs.push_back('{3, 4032, 0, 3'b111, 0, 1, 3, 0});
      vecs.push_back('{3, 4099, 0, 3'b111, 0, 1, 3, 0});
      vecs.push_back('{4,   62, 0, 3'b000, 1, 0, 0, 0});
      vecs.push_back('{4,   63, 0, 3'b111, 0, 0, 0, 1});
      vecs.push_back('{4,   82, 0, 3'b111, 0, 0, 0, 1});
      vecs.push_back('{4,   83, 0, 3'b110, 0, 0, 0, 1});
      vecs.push_back('{4,   87, 0, 3'b100, 0, 0, 0, 1});
      vecs.push_back('{4,   91, 0, 3'b000, 0, 0, 0, 1});
      vecs.push_back('{4,   92, 0, 3'b000, 1, 0, 0, 1});
      vecs.push_back('{5,   45, 0, 3'b100, 0, 0, 0, 0});
      vecs.push_back('{5,   46, 0, 3'b111, 0, 0, 0, 1});
      vecs.push_back('{5,   63, 0, 3'b111, 0, 0, 0, 1});
      vecs.push_back('{5,   64, 0, 3'b110, 0, 0, 0, 1});
      vecs.push_back('{5,   72, 0, 3'b000, 0, 0, 0, 1});
      vecs.push_back('{5,   73, 0, 3'b000, 1, 0, 0, 1});
      vecs.push_back('{6,   40, 0, 3'b110, 0, 0, 0, 0});
      vecs.push_back('{6,   41, 1, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{6,   48, 1, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{6,   49, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{6,   64, 0, 3'b111, 0, 0, 0, 0});
      vecs.push_back('{6,   65, 0, 3'b110, 0, 0, 0, 0});
      vecs.push_back('{6,   73, 0, 3'b000, 0, 0, 0, 0});
      vecs.push_back('{6,   74, 0, 3'b000, 1, 0, 0, 0});
      vecs.push_back('{7, 1117, 0, 3'b111, 0, 0, 1, 0});
      vecs.push_back('{7, 1118, 0, 3'b110, 0, 0, 1, 0});
      vecs.push_back('{7, 1126, 0, 3'b000, 0, 0, 1, 0});
      vecs.push_back('{7, 1127, 0, 3'b000, 1, 0, 0, 0});
      foreach (scens[s]) begin
         run(scens[s]);
         foreach (vecs[v]) if (vecs[v].sc == scens[s].sc) begin
            chk($sformatf("sc%0d mmcm_rst", vecs[v].sc), vecs[v].n, int'(cap_mm[vecs[v].n]), int'(vecs[v].mm));
            chk($sformatf("sc%0d rst_out", vecs[v].sc), vecs[v].n, int'(cap_ro[vecs[v].n]), int'(vecs[v].ro));
            chk($sformatf("sc%0d ready", vecs[v].sc), vecs[v].n, int'(cap_rd[vecs[v].n]), int'(vecs[v].rd));
            chk($sformatf("sc%0d fault", vecs[v].sc), vecs[v].n, int'(cap_ft[vecs[v].n]), int'(vecs[v].ft));
            chk($sformatf("sc%0d retry_cnt", vecs[v].sc), vecs[v].n, int'(cap_rc[vecs[v].n]), int'(vecs[v].rc));
            chk($sformatf("sc%0d lock_loss_cnt", vecs[v].sc), vecs[v].n, int'(cap_lc[vecs[v].n]), vecs[v].lc);
         end
      end
      // reset out of FAULT, then a clean bring-up with locked already high
      run('{8, 4040, -1, -1, 0, -1});
      chk("fault_sticky", 4040, int'(fault), 1);
      sys_rst = 1'b1;
      locked  = 1'b1;
      @(negedge clk);
      chk("fault_rst fault", 0, int'(fault), 0);
      chk("fault_rst mmcm_rst", 0, int'(mmcm_rst), 1);
      chk("fault_rst retry_cnt", 0, int'(retry_cnt), 0);
      chk("fault_rst rst_out", 0, int'(rst_out), 7);
      sys_rst = 1'b0;
      k = 0;
      while (!ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("fault_rst ready_cycle", k, k, 33);
      chk("fault_rst rst_out_at_ready", k, int'(rst_out), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
